uart_tx_arb: RTL and testbench

Byte-level arbiter and sequencer that shares the single RS232 transmit path between two FIFO-backed requesters, for example SDRAM read data (source A) and status/message bytes (source B). It pops one byte at a time from the granted FIFO, presents it on `tx_data`, pulses `tx_start` to the UART transmitter, and waits for that byte's completion before scheduling the next one. Arbitration is round-robin with a bounded burst length, plus a watchdog in case the transmitter never completes.

---
 rtl/uart_tx_arb.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART transmitter between two FIFO sources using
// round-robin arbitration with a burst limit and a tx_done watchdog.
module uart_tx_arb #(
  parameter int BURST_MAX = 16,
  parameter int TIMEOUT   = 32768
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_empty,
  input  logic [7:0] a_data,
  output logic       a_rdreq,
  input  logic       b_empty,
  input  logic [7:0] b_data,
  output logic       b_rdreq,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic       err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_START, S_WAIT} state_t;

  localparam logic [7:0]  BURST_LIM = 8'(BURST_MAX);
  localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        last_reg, last_next;        // owner of the latest byte: 0 = A, 1 = B
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] wd_reg, wd_next;
  logic        a_rdreq_reg, a_rdreq_next;
  logic        b_rdreq_reg, b_rdreq_next;
  logic        tx_start_reg, tx_start_next;
  logic        err_reg, err_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic [1:0]  grant_reg, grant_next;

  logic req_a, req_b, req_last, req_other, keep, sel, go, wd_expired;

  assign req_a      = ~a_empty;
  assign req_b      = ~b_empty;
  assign go         = req_a | req_b;
  assign wd_expired = (wd_reg == WD_LAST);

  // A zero burst count means no owner since reset, so a tie goes to A.
  always_comb begin
    req_last  = last_reg ? req_b : req_a;
    req_other = last_reg ? req_a : req_b;
    keep      = req_last && (cnt_reg != 8'd0) && (!req_other || (cnt_reg < BURST_LIM));
    sel       = last_reg;
    if (keep)
      sel = last_reg;
    else if (req_a && req_b)
      sel = (cnt_reg == 8'd0) ? 1'b0 : ~last_reg;
    else
      sel = ~req_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      last_reg     <= 1'b1;
      cnt_reg      <= 8'd0;
      wd_reg       <= 16'd0;
      a_rdreq_reg  <= 1'b0;
      b_rdreq_reg  <= 1'b0;
      tx_start_reg <= 1'b0;
      err_reg      <= 1'b0;
      tx_data_reg  <= 8'h00;
      grant_reg    <= 2'b00;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
      wd_reg       <= wd_next;
      a_rdreq_reg  <= a_rdreq_next;
      b_rdreq_reg  <= b_rdreq_next;
      tx_start_reg <= tx_start_next;
      err_reg      <= err_next;
      tx_data_reg  <= tx_data_next;
      grant_reg    <= grant_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (go) state_next = S_READ;
      S_READ:  state_next = S_LATCH;
      S_LATCH: state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (tx_done || wd_expired) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output values are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    a_rdreq_next  = 1'b0;
    b_rdreq_next  = 1'b0;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    grant_next    = grant_reg;
    err_next      = err_reg;
    last_next     = last_reg;
    cnt_next      = cnt_reg;
    wd_next       = wd_reg;
    case (state_reg)
      S_IDLE: begin
        if (go) begin
          a_rdreq_next = ~sel;
          b_rdreq_next = sel;
          grant_next   = sel ? 2'b10 : 2'b01;
          last_next    = sel;
          if ((sel == last_reg) && (cnt_reg != 8'd0))
            cnt_next = (cnt_reg >= BURST_LIM) ? cnt_reg : cnt_reg + 8'd1;
          else
            cnt_next = 8'd1;
        end
      end
      S_LATCH: begin
        tx_data_next  = last_reg ? b_data : a_data;
        tx_start_next = 1'b1;
      end
      S_START: wd_next = 16'd0;
      S_WAIT: begin
        wd_next = wd_reg + 16'd1;
        if (!tx_done && wd_expired) err_next = 1'b1;
        if (tx_done || wd_expired) grant_next = 2'b00;
      end
      default: ;
    endcase
  end

  assign a_rdreq     = a_rdreq_reg;
  assign b_rdreq     = b_rdreq_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign grant       = grant_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: FIFO models for A and B, tx_done driven per byte.
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_empty, b_empty;
  logic [7:0] a_data = 8'h00;
  logic [7:0] b_data = 8'h00;
  logic       a_rdreq, b_rdreq;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic [1:0] grant;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  logic [7:0] a_mem [0:255];
  logic [7:0] b_mem [0:255];
  int a_wr = 0;
  int b_wr = 0;
  int a_rd = 0;
  int b_rd = 0;

  assign a_empty = (a_rd == a_wr);
  assign b_empty = (b_rd == b_wr);

  always #5 clk = ~clk;

  // Show-ahead-free FIFO read: data appears the cycle after rdreq.
  always @(posedge clk) begin
    if (a_rdreq) begin
      a_data <= a_mem[a_rd[7:0]];
      a_rd   <= a_rd + 1;
    end
    if (b_rdreq) begin
      b_data <= b_mem[b_rd[7:0]];
      b_rd   <= b_rd + 1;
    end
  end

  uart_tx_arb #(.BURST_MAX(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_empty(a_empty), .a_data(a_data), .a_rdreq(a_rdreq),
    .b_empty(b_empty), .b_data(b_data), .b_rdreq(b_rdreq),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .grant(grant), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] v);
    a_mem[a_wr[7:0]] = v;
    a_wr++;
  endtask

  task automatic push_b(input logic [7:0] v);
    b_mem[b_wr[7:0]] = v;
    b_wr++;
  endtask

  task automatic wait_rdreq(input string tag, output int waited);
    waited = 0;
    while (!(a_rdreq || b_rdreq) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!(a_rdreq || b_rdreq)) chk({tag, "_rdreq_timeout"}, 32'd0, 32'd1);
  endtask

  // One full byte: rdreq -> LATCH -> START -> WAIT, tx_done in the first WAIT cycle.
  task automatic xfer(input string tag, input logic [7:0] exp_d, input logic [1:0] exp_g,
                      output int waited);
    wait_rdreq(tag, waited);
    if (!(a_rdreq || b_rdreq)) return;
    chk({tag, "_rdreq"}, 32'({b_rdreq, a_rdreq}), 32'(exp_g));
    chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
    @(negedge clk);
    chk({tag, "_rdreq_pulse"}, 32'({b_rdreq, a_rdreq}), 32'd0);
    @(negedge clk);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd1);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'(exp_d));
    @(negedge clk);
    chk({tag, "_start_drop"}, 32'(tx_start), 32'd0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk({tag, "_grant_idle"}, 32'(grant), 32'd0);
    $display("xfer %s data=%02h grant=%b wait=%0d", tag, tx_data, exp_g, waited);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    logic [7:0] burst_d [0:11];
    logic [1:0] burst_g [0:11];

    tx_done = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    chk("rst_a_rdreq", 32'(a_rdreq), 32'd0);
    chk("rst_b_rdreq", 32'(b_rdreq), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_grant", 32'(grant), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source A: three bytes in order, B never read.
    push_a(8'h41); push_a(8'h42); push_a(8'h43);
    xfer("single0", 8'h41, 2'b01, w);
    xfer("single1", 8'h42, 2'b01, w);
    xfer("single2", 8'h43, 2'b01, w);
    repeat (3) @(negedge clk);
    chk("single_idle_rdreq", 32'({b_rdreq, a_rdreq}), 32'd0);

    // Tie right after reset goes to A.
    do_reset();
    push_a(8'h51); push_b(8'h61);
    xfer("tie_a", 8'h51, 2'b01, w);
    xfer("tie_b", 8'h61, 2'b10, w);

    // Burst limit 4: A x4, B x2, A x6, back to back.
    do_reset();
    for (int i = 0; i < 10; i++) push_a(8'hA0 + 8'(i));
    push_b(8'hB0); push_b(8'hB1);
    for (int i = 0; i < 4; i++) begin burst_d[i] = 8'hA0 + 8'(i); burst_g[i] = 2'b01; end
    burst_d[4] = 8'hB0; burst_g[4] = 2'b10;
    burst_d[5] = 8'hB1; burst_g[5] = 2'b10;
    for (int i = 6; i < 12; i++) begin burst_d[i] = 8'hA4 + 8'(i - 6); burst_g[i] = 2'b01; end
    for (int i = 0; i < 12; i++) begin
      xfer($sformatf("burst%0d", i), burst_d[i], burst_g[i], w);
      if (i > 0) chk($sformatf("burst%0d_gap", i), 32'(w), 32'd1);
    end

    // Unbounded burst: B empty, A never preempted, no extra idle cycles.
    for (int i = 0; i < 20; i++) push_a(8'hC0 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      xfer($sformatf("unb%0d", i), 8'hC0 + 8'(i), 2'b01, w);
      chk($sformatf("unb%0d_gap", i), 32'(w), 32'd1);
    end

    // Watchdog: tx_done withheld for the first byte.
    push_a(8'hD0); push_a(8'hD1);
    wait_rdreq("wd", w);
    @(negedge clk);
    @(negedge clk);
    chk("wd_tx_data", 32'(tx_data), 32'hD0);
    @(negedge clk);
    repeat (99) @(negedge clk);
    chk("wd_err_early", 32'(err_timeout), 32'd0);
    chk("wd_grant_held", 32'(grant), 32'd1);
    @(negedge clk);
    chk("wd_err_set", 32'(err_timeout), 32'd1);
    chk("wd_grant_idle", 32'(grant), 32'd0);
    $display("xfer wd data=D0 dropped err=%b", err_timeout);
    xfer("wd_next", 8'hD1, 2'b01, w);
    chk("wd_next_gap", 32'(w), 32'd1);
    chk("wd_err_sticky", 32'(err_timeout), 32'd1);

    // Spurious tx_done in IDLE is ignored.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("spur%0d_out", i), 32'({grant, b_rdreq, a_rdreq, tx_start}), 32'd0);
      @(negedge clk);
    end
    chk("spur_err", 32'(err_timeout), 32'd1);

    // Reset during WAIT; afterwards the tie rule favours A again.
    push_a(8'hE0); push_b(8'hE1);
    wait_rdreq("rstw", w);
    chk("rstw_grant", 32'(grant), 32'b10);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_tx_data", 32'(tx_data), 32'hE1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_grant0", 32'(grant), 32'd0);
    chk("rstw_tx_data0", 32'(tx_data), 32'h00);
    chk("rstw_err0", 32'(err_timeout), 32'd0);
    chk("rstw_outs0", 32'({tx_start, b_rdreq, a_rdreq}), 32'd0);
    push_b(8'hE2);
    @(negedge clk);
    rst_n = 1'b1;
    xfer("post_rst_a", 8'hE0, 2'b01, w);
    xfer("post_rst_b", 8'hE2, 2'b10, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
